// File: rtl/sm_input_pkg.sv
// Shared definitions for the board input conditioner: repeat-FSM states and
// default timing constants for a 50 MHz board clock.
package sm_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // 10 ms debounce, 0.5 s before the first repeat, 10 repeats per second
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

endpackage

// File: rtl/sm_debounce.sv
// One-bit synchronizer plus debouncer. 'level' is the registered stable value;
// 'rise'/'fall' are strobes that are high during the cycle in which the next
// clock edge will accept a change, so a parent can register them and have the
// pulse line up exactly with the new level.
module sm_debounce
  import sm_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync_q != level) && (cnt == LAST);
  assign rise   = accept & sync_q;
  assign fall   = accept & ~sync_q;

  // Two-flop synchronizer for the asynchronous raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Count consecutive cycles of disagreement; any return to the stable value restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      level <= sync_q;
      cnt   <= '0;
    end else if (sync_q != level) begin
      cnt   <= cnt + CW'(1);
    end else begin
      cnt   <= '0;
    end
  end

endmodule

// File: rtl/sm_user_input.sv
// Board-side input conditioner: debounced key and switch levels, registered
// press/release/change pulses and per-key auto-repeat.
module sm_user_input
  import sm_input_pkg::*;
#(
  parameter int KEY_W           = 4,
  parameter int SW_W            = 10,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_n,
  input  logic [SW_W-1:0]  sw,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_repeat,
  output logic [SW_W-1:0]  sw_level,
  output logic [SW_W-1:0]  sw_change
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [KEY_W-1:0] key_rise;
  logic [KEY_W-1:0] key_fall;
  logic [SW_W-1:0]  sw_rise;
  logic [SW_W-1:0]  sw_fall;

  // Keys are active-low on the board; invert so internal 1 means pressed
  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (~key_n[i]),
      .level (key_level[i]),
      .rise  (key_rise[i]),
      .fall  (key_fall[i])
    );
  end

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw[i]),
      .level (sw_level[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  // Register the accept strobes so each pulse appears with its new level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_press   <= '0;
      key_release <= '0;
      sw_change   <= '0;
    end else begin
      key_press   <= key_rise;
      key_release <= key_fall;
      sw_change   <= sw_rise | sw_fall;
    end
  end

  if (REPEAT_DELAY == 0) begin : g_no_repeat
    assign key_repeat = '0;
  end else begin : g_repeat
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    for (genvar i = 0; i < KEY_W; i++) begin : g_fsm
      rpt_state_t    state_q, state_d;
      logic [RW-1:0] rcnt_q, rcnt_d;
      logic          rep_q, rep_d;

      // State, hold counter and registered repeat pulse
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= ST_IDLE;
          rcnt_q  <= '0;
          rep_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
          rep_q   <= rep_d;
        end
      end

      // A release accepted on the same edge as a due repeat suppresses it
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rep_d   = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (key_rise[i]) begin
              state_d = ST_HOLD;
              rcnt_d  = '0;
            end
          end
          ST_HOLD: begin
            if (key_fall[i]) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == DELAY_LAST) begin
              state_d = ST_REPEAT;
              rcnt_d  = '0;
              rep_d   = 1'b1;
            end else begin
              rcnt_d  = rcnt_q + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (key_fall[i]) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == RATE_LAST) begin
              rcnt_d  = '0;
              rep_d   = 1'b1;
            end else begin
              rcnt_d  = rcnt_q + RW'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end

      assign key_repeat[i] = rep_q;
    end
  end

endmodule

// File: tb/tb_sm_user_input.sv
// Self-checking bench for sm_user_input: a scoreboard of expected pulse
// events keyed by clock edge, checked every cycle against two instances
// (auto-repeat enabled and disabled) driven by the same inputs.
module tb_sm_user_input;

  localparam int KEY_W = 4;
  localparam int SW_W  = 10;
  localparam int DC    = 4;
  localparam int RD    = 10;
  localparam int RR    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [KEY_W-1:0] key_n;
  logic [SW_W-1:0]  sw;

  logic [KEY_W-1:0] key_level, key_press, key_release, key_repeat;
  logic [SW_W-1:0]  sw_level, sw_change;
  logic [KEY_W-1:0] nr_key_level, nr_key_press, nr_key_release, nr_key_repeat;
  logic [SW_W-1:0]  nr_sw_level, nr_sw_change;

  sm_user_input #(
    .KEY_W(KEY_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .sw(sw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .sw_level(sw_level), .sw_change(sw_change)
  );

  sm_user_input #(
    .KEY_W(KEY_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(0), .REPEAT_RATE(RR)
  ) dut_nr (
    .clk(clk), .rst(rst), .key_n(key_n), .sw(sw),
    .key_level(nr_key_level), .key_press(nr_key_press), .key_release(nr_key_release),
    .key_repeat(nr_key_repeat), .sw_level(nr_sw_level), .sw_change(nr_sw_change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_REPEAT, EV_SWCHG} ev_kind_t;
  typedef struct {
    int       cyc;
    ev_kind_t kind;
    int       idx;
  } ev_t;

  ev_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  logic [KEY_W-1:0] exp_key_level = '0;
  logic [SW_W-1:0]  exp_sw_level  = '0;

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s at cycle %0d: observed=0x%h expected=0x%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input ev_kind_t k, input int idx);
    sb.push_back('{cyc: c, kind: k, idx: idx});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_key_level"},      16'(key_level),      16'd0);
    check_output({tag, "_key_press"},      16'(key_press),      16'd0);
    check_output({tag, "_key_release"},    16'(key_release),    16'd0);
    check_output({tag, "_key_repeat"},     16'(key_repeat),     16'd0);
    check_output({tag, "_sw_level"},       16'(sw_level),       16'd0);
    check_output({tag, "_sw_change"},      16'(sw_change),      16'd0);
    check_output({tag, "_nr_key_level"},   16'(nr_key_level),   16'd0);
    check_output({tag, "_nr_sw_level"},    16'(nr_sw_level),    16'd0);
  endtask

  // Press a key at the current edge, hold it, release it, and queue every
  // pulse the timing rules predict: press and release DC+2 edges after the
  // raw changes, repeats RD after the press and then every RR, none on or
  // after the release edge.
  task automatic apply_stimulus(input int idx, input int hold);
    int e, p, r;
    e = cyc;
    p = e + DC + 2;
    r = e + hold + DC + 2;
    key_n[idx] = 1'b0;
    push(p, EV_PRESS, idx);
    for (int t = p + RD; t < r; t += RR) push(t, EV_REPEAT, idx);
    push(r, EV_RELEASE, idx);
    wait_cycles(hold);
    key_n[idx] = 1'b1;
    wait_cycles(DC + 2 + 4);
  endtask

  // Every falling edge: collect the events due now and compare all outputs
  always @(negedge clk) begin : scoreboard
    logic [KEY_W-1:0] e_press, e_rel, e_rep;
    logic [SW_W-1:0]  e_sw;
    e_press = '0;
    e_rel   = '0;
    e_rep   = '0;
    e_sw    = '0;
    if (rst) begin
      exp_key_level = '0;
      exp_sw_level  = '0;
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          EV_PRESS:   e_press[sb[i].idx] = 1'b1;
          EV_RELEASE: e_rel[sb[i].idx]   = 1'b1;
          EV_REPEAT:  e_rep[sb[i].idx]   = 1'b1;
          default:    e_sw[sb[i].idx]    = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    exp_key_level = (exp_key_level | e_press) & ~e_rel;
    exp_sw_level  = exp_sw_level ^ e_sw;
    check_output("key_level",      16'(key_level),      16'(exp_key_level));
    check_output("key_press",      16'(key_press),      16'(e_press));
    check_output("key_release",    16'(key_release),    16'(e_rel));
    check_output("key_repeat",     16'(key_repeat),     16'(e_rep));
    check_output("sw_level",       16'(sw_level),       16'(exp_sw_level));
    check_output("sw_change",      16'(sw_change),      16'(e_sw));
    check_output("nr_key_level",   16'(nr_key_level),   16'(exp_key_level));
    check_output("nr_key_press",   16'(nr_key_press),   16'(e_press));
    check_output("nr_key_release", 16'(nr_key_release), 16'(e_rel));
    check_output("nr_key_repeat",  16'(nr_key_repeat),  16'd0);
    check_output("nr_sw_change",   16'(nr_sw_change),   16'(e_sw));
  end

  initial begin
    int e;
    rst   = 1'b1;
    key_n = '1;
    sw    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    wait_cycles(3);

    $display("[TB] clean press on key 1");
    apply_stimulus(1, 8);

    $display("[TB] bounce rejection on sw[3]");
    e = cyc;
    for (int k = 0; k < 10; k++) begin
      sw[3] = ~sw[3];
      wait_cycles(2);
    end
    sw[3] = 1'b1;
    push(e + 20 + DC + 2, EV_SWCHG, 3);
    wait_cycles(12);

    $display("[TB] auto-repeat on key 0");
    apply_stimulus(0, 36);

    $display("[TB] release coincident with a repeat (REPEAT and HOLD states)");
    apply_stimulus(0, 13);
    apply_stimulus(2, 10);

    $display("[TB] simultaneous switch changes");
    e = cyc;
    sw[0] = 1'b1;
    sw[9] = 1'b1;
    push(e + DC + 2, EV_SWCHG, 0);
    push(e + DC + 2, EV_SWCHG, 9);
    wait_cycles(10);
    e = cyc;
    sw[0] = 1'b0;
    sw[9] = 1'b0;
    sw[3] = 1'b0;
    push(e + DC + 2, EV_SWCHG, 0);
    push(e + DC + 2, EV_SWCHG, 9);
    push(e + DC + 2, EV_SWCHG, 3);
    wait_cycles(10);

    $display("[TB] long hold on key 3 (repeat disabled instance stays quiet)");
    apply_stimulus(3, 100);

    $display("[TB] reset during HOLD and switch debounce");
    e = cyc;
    key_n[2] = 1'b0;
    push(e + DC + 2, EV_PRESS, 2);
    wait_cycles(7);
    sw[5] = 1'b1;
    wait_cycles(2);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    key_n[2] = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    e = cyc;
    for (int b = 0; b < SW_W; b++) begin
      if (sw[b]) push(e + DC + 2, EV_SWCHG, b);
    end
    wait_cycles(12);

    wait_cycles(3);
    check_output("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
